// File: rtl/insai_wb_queue_if.sv
// Shared types for the insAI writeback queue, plus the FU-result / writeback-port bundle.
// The bundle has no state; the slave modport is the queue and the master modport is its environment.
package insai_wb_queue_pkg;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef logic [XLEN-1:0] xlen_t;

    typedef struct packed {
        xlen_t cause;
        xlen_t tval;
        logic  valid;
    } exception_t;

    typedef struct packed {
        int unsigned XLEN;
    } cfg_t;

    localparam cfg_t cva6_cfg_empty = '{XLEN: 32};
endpackage

interface insai_wb_queue_if;
    import insai_wb_queue_pkg::*;

    logic                     fu_valid;
    xlen_t                    fu_result;
    logic [TRANS_ID_BITS-1:0] fu_trans_id;
    exception_t               fu_exception;
    logic                     fu_ready;

    logic                     wb_grant;
    logic                     wb_valid;
    xlen_t                    wb_result;
    logic [TRANS_ID_BITS-1:0] wb_trans_id;
    exception_t               wb_exception;

    modport slave (
        input  fu_valid, fu_result, fu_trans_id, fu_exception, wb_grant,
        output fu_ready, wb_valid, wb_result, wb_trans_id, wb_exception
    );

    modport master (
        output fu_valid, fu_result, fu_trans_id, fu_exception, wb_grant,
        input  fu_ready, wb_valid, wb_result, wb_trans_id, wb_exception
    );
endinterface

// File: rtl/insai_wb_queue.sv
// In-order result queue between the custom FU and a grant-gated writeback port.
// Latency 0 when empty (bypass), else the head is shown the cycle after its push.
// Back-pressure: fu_ready drops when full, from registered count only; arrivals while full are dropped and flagged.
module insai_wb_queue
    import insai_wb_queue_pkg::*;
#(
    parameter cfg_t        CVA6Cfg = cva6_cfg_empty,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    insai_wb_queue_if.slave           bus_io,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o
);
    localparam int unsigned RES_W = CVA6Cfg.XLEN;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;

    typedef struct packed {
        logic [RES_W-1:0]         result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        exception_t               exception;
    } entry_t;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    entry_t        mem_q [DEPTH];

    entry_t in_entry;
    entry_t out_entry;
    logic   empty, full, push, pop, wb_vld;

    assign in_entry = '{result: bus_io.fu_result, trans_id: bus_io.fu_trans_id,
                        exception: bus_io.fu_exception};

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // An empty queue forwards the incoming result directly; it is only stored if the grant misses it.
    assign wb_vld = !flush_i && (!empty || bus_io.fu_valid);
    assign pop    = wb_vld && bus_io.wb_grant && !empty;
    assign push   = bus_io.fu_valid && !full && !flush_i && !(empty && bus_io.wb_grant);

    always_comb begin
        out_entry = '0;
        if (wb_vld) begin
            out_entry = empty ? in_entry : mem_q[rd_ptr_q];
        end
    end

    assign bus_io.fu_ready     = !full;
    assign bus_io.wb_valid     = wb_vld;
    assign bus_io.wb_result    = out_entry.result;
    assign bus_io.wb_trans_id  = out_entry.trans_id;
    assign bus_io.wb_exception = out_entry.exception;
    assign count_o             = count_q;
    assign overflow_o          = overflow_q;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // A pop in the same cycle does not make room for an arrival seen while full.
            if (bus_io.fu_valid && full) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end
endmodule
